// File: rtl/vec_store_unit.sv
// Vector store unit: snapshots one 512-bit vector register from the register
// file read port and streams it to memory as BEATS words over valid/ready.
module vec_store_unit #(
  parameter int WORD_W = 32,
  parameter int VEC_W  = 512,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        src_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [1:0]        rf_r_reg,
  input  logic [VEC_W-1:0]  rf_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int BEATS = VEC_W / WORD_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  beat;
  logic [CNT_W-1:0]  beat_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [VEC_W-1:0]  snapshot;

  // Index of the beat that follows the current one
  always_comb begin
    beat_nxt = beat + CNT_W'(1);
  end

  // Command FSM with registered handshake, address and data outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rf_r_reg  <= '0;
      base_q    <= '0;
      beat      <= '0;
      snapshot  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_r_reg <= src_reg;
            base_q   <= base_addr;
            beat     <= '0;
            busy     <= 1'b1;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Beat 0 is loaded straight from rf_data, which is the value the
          // snapshot takes at this same edge.
          snapshot  <= rf_data;
          mem_addr  <= base_q;
          mem_wdata <= rf_data[WORD_W-1:0];
          mem_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (mem_ready) begin
            if (beat == LAST_BEAT) begin
              mem_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              beat      <= beat_nxt;
              mem_addr  <= base_q + ADDR_W'(beat_nxt);
              mem_wdata <= snapshot[WORD_W*beat_nxt +: WORD_W];
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vec_store_unit.md
# vec_store_unit

Vector store unit that reads one 512-bit vector register through the register file's read port and streams it to memory as sixteen 32-bit words over a valid/ready write channel. It sits between the four-entry vector register file and the data-memory write port. It is the reader counterpart to the register file's dual write ports. A single command stores a whole register at consecutive word addresses starting from a base address.

## Interface
Parameters:
- WORD_W, 32, memory word width in bits
- VEC_W, 512, vector register width; must be an integer multiple of WORD_W
- ADDR_W, 32, memory word-address width
- BEATS, VEC_W/WORD_W (16), derived, not overridable

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  command strobe; sampled only when busy == 0
- src_reg  in  2  index of the vector register to store
- base_addr  in  ADDR_W  word address of beat 0
- rf_r_reg  out  2  register-file read select (registered)
- rf_data  in  VEC_W  register-file read data, combinational from rf_r_reg
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  word address of the current beat
- mem_wdata  out  WORD_W  data of the current beat
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, CAPTURE, SEND, DONE.
- IDLE: if start == 1, latch src_reg into rf_r_reg, latch base_addr, clear beat counter, go to CAPTURE.
- CAPTURE: at the edge, copy rf_data into an internal VEC_W snapshot buffer, then go to SEND.
  - Snapshot semantics: register-file writes to src_reg after this edge do not affect the stored data.
- SEND: mem_valid = 1.
  - mem_wdata = snapshot[WORD_W*i +: WORD_W] and mem_addr = base + i, where i is the beat counter (0..BEATS-1).
  - On mem_valid && mem_ready, i increments.
  - After beat BEATS-1 is accepted, go to DONE.
- DONE: done = 1 for exactly one cycle, mem_valid = 0, then go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W (base = all-ones gives addresses FFFFFFFF, 0, 1, ...).
- start asserted while busy == 1 is ignored; it is not queued.
- rf_r_reg holds its last value in IDLE and is not cleared by done.

## Timing
- Reset values, applied asynchronously on reset = 0:
  - state = IDLE
  - rf_r_reg = 0, mem_valid = 0, mem_addr = 0, mem_wdata = 0, busy = 0, done = 0
  - beat counter = 0, snapshot = 0
- Reset asserted mid-transfer aborts immediately: mem_valid drops without waiting for mem_ready, no done pulse is produced, and the remaining beats are lost.
- Cycle numbering with start sampled at edge E0:
  - busy rises after E0, in the CAPTURE cycle.
  - Snapshot is taken at E1; rf_r_reg has been stable for the full cycle, and register-file writes land on negedge, so they are settled before E1.
  - First mem_valid appears after E1.
  - With mem_ready held at 1, beats occupy 16 consecutive cycles, done is high in the cycle after the last beat, and busy falls one cycle later.
  - Best-case command-to-done latency: 18 cycles. Next start is accepted at the first edge with busy == 0.
- Handshake rules:
  - While mem_valid = 1 and mem_ready = 0, mem_addr and mem_wdata hold stable.
  - mem_valid never deasserts in SEND before acceptance.
  - mem_ready is ignored outside SEND.
- mem_ready toggling at any rate only stretches SEND. Each beat is transferred exactly once.

## Test plan
- Reset then idle: reset = 0 for 3 cycles, release -> all outputs 0; with no start, mem_valid stays 0 for 50 cycles.
- Basic store: regs[2] = {16 words 0x00..0x0F pattern, word i = 0x1000+i}, start with src_reg = 2, base_addr = 0x100, mem_ready = 1 -> rf_r_reg = 2; beats addr 0x100..0x10F carry data 0x1000..0x100F in order; done pulses exactly once, 18 cycles after start.
- Backpressure: same command, mem_ready random 30% high -> identical 16 (addr, data) pairs with no duplicates; addr and data are stable whenever valid is high and ready is low.
- Snapshot and ignored start:
  - Overwrite regs[2] via register-file write port 1 during beat 5 -> remaining beats still carry the old data.
  - Assert start with src_reg = 3 during SEND -> no second transfer occurs.
- Address wrap: base_addr = 0xFFFFFFFE -> beat addresses FFFFFFFE, FFFFFFFF, 0, 1, ..., 0xD.
- Reset mid-operation: assert reset at beat 7 while mem_ready = 0 -> mem_valid = 0 and busy = 0 asynchronously, with no done pulse; a new command after release completes normally.
